// File: rtl/l2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_pkg : widths, state/op encodings and address helpers for the L2 responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package l2_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  localparam int INDEX_BITS  = 6;
  localparam int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_LINES   = 1 << INDEX_BITS;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [LINE_W-1:0]     line_t;
  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [INDEX_BITS-1:0] idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_WB      = 3'd2,
    ST_FILL    = 3'd3,
    ST_RESP    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic idx_t addr_idx(input addr_t a);
    return a[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic addr_t line_addr(input tag_t t, input idx_t i);
    return {t, i, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_l1d_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_l1d_responder_if : L1D<->L2 line request bus plus the next-level memory port
// Revision: 1.0
// ---------------------------------------------------------------------------
interface l2_l1d_responder_if;
  import l2_pkg::*;

  logic  re_L1D_L2;
  addr_t raddr_L1D_L2;
  line_t rdata_L1D_L2;
  logic  read_hit_L1D_L2;
  logic  we_L1D_L2;
  addr_t waddr_L1D_L2;
  line_t wdata_L1D_L2;
  logic  write_hit_L1D_L2;

  logic  mem_req_o;
  logic  mem_we_o;
  addr_t mem_addr_o;
  line_t mem_wdata_o;
  line_t mem_rdata_i;
  logic  mem_ack_i;

  modport slave (
    input  re_L1D_L2, raddr_L1D_L2, we_L1D_L2, waddr_L1D_L2, wdata_L1D_L2,
    input  mem_rdata_i, mem_ack_i,
    output rdata_L1D_L2, read_hit_L1D_L2, write_hit_L1D_L2,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output re_L1D_L2, raddr_L1D_L2, we_L1D_L2, waddr_L1D_L2, wdata_L1D_L2,
    output mem_rdata_i, mem_ack_i,
    input  rdata_L1D_L2, read_hit_L1D_L2, write_hit_L1D_L2,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface
`default_nettype wire

// File: rtl/l2_line_store.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_line_store : direct-mapped data/tag/valid/dirty arrays, one write port,
//                 combinational read by index
// Revision: 1.0
// ---------------------------------------------------------------------------
module l2_line_store
  import l2_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  logic  wr_meta_only,
  input  idx_t  wr_idx,
  input  tag_t  wr_tag,
  input  line_t wr_line,
  input  logic  wr_valid,
  input  logic  wr_dirty,
  input  idx_t  rd_idx,
  output line_t rd_line,
  output tag_t  rd_tag,
  output logic  rd_valid,
  output logic  rd_dirty
);

  line_t                data_q [NUM_LINES];
  tag_t                 tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_meta_only) begin
      data_q[wr_idx] <= wr_line;
      tag_q[wr_idx]  <= wr_tag;
    end
  end

  assign rd_line  = data_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/l2_l1d_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2_l1d_responder : L2 responder for full-line L1D requests, write-back /
//                    write-allocate line store with fill/evict memory port
// Revision: 1.0
// ---------------------------------------------------------------------------
module l2_l1d_responder
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  l2_l1d_responder_if.slave bus,
  output logic              busy_o
);

  state_t state, state_nx;
  op_t    op_q;
  tag_t   req_tag_q;
  idx_t   req_idx_q;
  line_t  wdata_q;
  logic   mem_gap_q;
  logic   read_hit_q, write_hit_q;
  line_t  rdata_q;

  logic   st_wr_en, st_wr_meta_only, st_wr_valid, st_wr_dirty;
  tag_t   st_wr_tag;
  line_t  st_wr_line;
  line_t  st_rd_line;
  tag_t   st_rd_tag;
  logic   st_rd_valid, st_rd_dirty;
  logic   hit, victim_dirty;

  logic   mem_req, mem_we;
  addr_t  mem_addr;
  line_t  mem_wdata;

  logic   unused_offset;
  assign  unused_offset = ^{bus.raddr_L1D_L2[OFFSET_BITS-1:0], bus.waddr_L1D_L2[OFFSET_BITS-1:0]};

  l2_line_store u_store (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (st_wr_en),
    .wr_meta_only (st_wr_meta_only),
    .wr_idx       (req_idx_q),
    .wr_tag       (st_wr_tag),
    .wr_line      (st_wr_line),
    .wr_valid     (st_wr_valid),
    .wr_dirty     (st_wr_dirty),
    .rd_idx       (req_idx_q),
    .rd_line      (st_rd_line),
    .rd_tag       (st_rd_tag),
    .rd_valid     (st_rd_valid),
    .rd_dirty     (st_rd_dirty)
  );

  assign hit          = st_rd_valid && (st_rd_tag == req_tag_q);
  assign victim_dirty = st_rd_valid && st_rd_dirty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Read wins arbitration; a concurrent write stays asserted and is taken later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_READ;
      req_tag_q <= '0;
      req_idx_q <= '0;
      wdata_q   <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.re_L1D_L2) begin
        op_q      <= OP_READ;
        req_tag_q <= addr_tag(bus.raddr_L1D_L2);
        req_idx_q <= addr_idx(bus.raddr_L1D_L2);
      end else if (bus.we_L1D_L2) begin
        op_q      <= OP_WRITE;
        req_tag_q <= addr_tag(bus.waddr_L1D_L2);
        req_idx_q <= addr_idx(bus.waddr_L1D_L2);
        wdata_q   <= bus.wdata_L1D_L2;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    st_wr_en        = 1'b0;
    st_wr_meta_only = 1'b0;
    st_wr_tag       = req_tag_q;
    st_wr_line      = wdata_q;
    st_wr_valid     = 1'b1;
    st_wr_dirty     = 1'b1;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    case (state)
      ST_IDLE: begin
        if (bus.re_L1D_L2 || bus.we_L1D_L2) state_nx = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (op_q == OP_READ) begin
          if (hit)               state_nx = ST_RESP;
          else if (victim_dirty) state_nx = ST_WB;
          else                   state_nx = ST_FILL;
        end else if (!hit && victim_dirty) begin
          state_nx = ST_WB;
        end else begin
          st_wr_en = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(st_rd_tag, req_idx_q);
        mem_wdata = st_rd_line;
        if (bus.mem_ack_i) begin
          st_wr_en = 1'b1;
          if (op_q == OP_READ) begin
            st_wr_meta_only = 1'b1;
            st_wr_dirty     = 1'b0;
            state_nx        = ST_FILL;
          end else begin
            state_nx = ST_RESP;
          end
        end
      end
      ST_FILL: begin
        // First FILL cycle after a write-back keeps the request low for one cycle.
        mem_req  = !mem_gap_q;
        mem_addr = line_addr(req_tag_q, req_idx_q);
        if (bus.mem_ack_i && !mem_gap_q) begin
          st_wr_en    = 1'b1;
          st_wr_line  = bus.mem_rdata_i;
          st_wr_dirty = 1'b0;
          state_nx    = ST_RESP;
        end
      end
      ST_RESP:    state_nx = ST_RECOVER;
      ST_RECOVER: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_gap_q   <= 1'b0;
      read_hit_q  <= 1'b0;
      write_hit_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mem_gap_q   <= (state == ST_WB) && bus.mem_ack_i && (op_q == OP_READ);
      read_hit_q  <= (state == ST_RESP) && (op_q == OP_READ);
      write_hit_q <= (state == ST_RESP) && (op_q == OP_WRITE);
      if ((state == ST_RESP) && (op_q == OP_READ)) rdata_q <= st_rd_line;
    end
  end

  assign bus.read_hit_L1D_L2  = read_hit_q;
  assign bus.write_hit_L1D_L2 = write_hit_q;
  assign bus.rdata_L1D_L2     = rdata_q;
  assign bus.mem_req_o        = mem_req;
  assign bus.mem_we_o         = mem_we;
  assign bus.mem_addr_o       = mem_addr;
  assign bus.mem_wdata_o      = mem_wdata;
  assign busy_o               = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l2_l1d_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_l2_l1d_responder : scoreboard bench with a flat-memory reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_l2_l1d_responder;
  import l2_pkg::*;

  typedef struct {
    bit    is_w;
    line_t data;
    int    exp_cyc;   // -1: one cycle after the last memory ack
  } resp_t;

  typedef struct {
    bit    we;
    addr_t addr;
    line_t wdata;
  } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  l2_l1d_responder_if bus();

  l2_l1d_responder dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack = 0;
  bit no_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  resp_t resp_q[$];
  mem_t  mem_q[$];

  // Reference: gold = latest architectural value per line; backing = next level.
  line_t gold    [addr_t];
  line_t backing [addr_t];
  bit    mv [NUM_LINES];
  bit    md [NUM_LINES];
  tag_t  mt [NUM_LINES];

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_l(input string nm, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed here", nm);
  endtask

  function automatic line_t pattern(input addr_t la);
    return {8{la ^ 32'h5A5A_C3C3}} ^ {la, 224'h0};
  endfunction

  function automatic line_t gold_of(input addr_t la);
    return gold.exists(la) ? gold[la] : pattern(la);
  endfunction

  function automatic line_t back_of(input addr_t la);
    return backing.exists(la) ? backing[la] : pattern(la);
  endfunction

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic predict(input bit is_w, input addr_t a, input line_t d, input int sample);
    addr_t la  = {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    idx_t  i   = addr_idx(a);
    tag_t  t   = addr_tag(a);
    bit    h   = mv[i] && (mt[i] == t);
    bit    evc = mv[i] && md[i] && !h;
    bit    fil = !is_w && !h;
    mem_t  m;
    resp_t r;
    if (evc) begin
      m.we = 1'b1; m.addr = line_addr(mt[i], i); m.wdata = gold_of(m.addr);
      mem_q.push_back(m);
    end
    if (fil) begin
      m.we = 1'b0; m.addr = la; m.wdata = '0;
      mem_q.push_back(m);
    end
    mv[i] = 1'b1;
    mt[i] = t;
    if (is_w) begin
      md[i]    = 1'b1;
      gold[la] = d;
    end else if (fil) begin
      md[i] = 1'b0;
    end
    r.is_w    = is_w;
    r.data    = is_w ? '0 : gold_of(la);
    r.exp_cyc = (evc || fil) ? -1 : sample + 2;
    resp_q.push_back(r);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("idle_timeout");
  endtask

  task automatic wait_hit(input bit is_w);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_w ? bus.write_hit_L1D_L2 : bus.read_hit_L1D_L2) && n < 400);
    if (n >= 400) fail(is_w ? "write_hit_timeout" : "read_hit_timeout");
  endtask

  task automatic do_op(input bit r, input bit w, input addr_t ra, input addr_t wa, input line_t wd);
    wait_idle();
    bus.re_L1D_L2    = r;
    bus.raddr_L1D_L2 = ra;
    bus.we_L1D_L2    = w;
    bus.waddr_L1D_L2 = wa;
    bus.wdata_L1D_L2 = wd;
    if (r) predict(1'b0, ra, '0, cyc + 1);
    else   predict(1'b1, wa, wd, cyc + 1);
    if (r) begin
      wait_hit(1'b0);
      bus.re_L1D_L2 = 1'b0;
      // Pending write is sampled on the second edge after the read pulse.
      if (w) predict(1'b1, wa, wd, cyc + 2);
    end
    if (w) begin
      wait_hit(1'b1);
      bus.we_L1D_L2 = 1'b0;
    end
  endtask

  // Response monitor
  initial begin
    bit    prev_hit = 1'b0;
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hit = 1'b0;
      end else if (bus.read_hit_L1D_L2 || bus.write_hit_L1D_L2) begin
        chk_i("pulse_width", int'(prev_hit), 0);
        chk_i("hit_exclusive", int'(bus.read_hit_L1D_L2 && bus.write_hit_L1D_L2), 0);
        if (resp_q.size() == 0) begin
          fail("unexpected_hit");
        end else begin
          r = resp_q.pop_front();
          chk_i("hit_kind", int'(bus.write_hit_L1D_L2), int'(r.is_w));
          if (!r.is_w) chk_l("rdata", bus.rdata_L1D_L2, r.data);
          chk_i("hit_cycle", cyc, (r.exp_cyc < 0) ? last_ack + 1 : r.exp_cyc);
        end
        prev_hit = 1'b1;
      end else begin
        prev_hit = 1'b0;
      end
    end
  end

  // Next-level memory responder
  initial begin
    bit   in_txn = 1'b0, ack_prev = 1'b0, prev_wb = 1'b0, want_req = 1'b0;
    int   dly = 0;
    mem_t cur, e;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.mem_ack_i = 1'b0;
        in_txn = 1'b0; ack_prev = 1'b0; want_req = 1'b0;
        continue;
      end
      if (want_req) begin
        chk_i("wb_fill_gap", int'(bus.mem_req_o), 1);
        want_req = 1'b0;
      end
      if (ack_prev) begin
        bus.mem_ack_i = 1'b0;
        ack_prev = 1'b0;
        chk_i("req_drop_after_ack", int'(bus.mem_req_o), 0);
        want_req = prev_wb && (mem_q.size() > 0) && !mem_q[0].we;
        continue;
      end
      if (bus.mem_req_o && !in_txn) begin
        if (mem_q.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          e = mem_q.pop_front();
          chk_i("mem_we", int'(bus.mem_we_o), int'(e.we));
          chk_i("mem_addr", int'(bus.mem_addr_o), int'(e.addr));
          if (e.we) chk_l("mem_wdata", bus.mem_wdata_o, e.wdata);
        end
        cur.we = bus.mem_we_o; cur.addr = bus.mem_addr_o; cur.wdata = bus.mem_wdata_o;
        in_txn = 1'b1;
        dly = $urandom_range(0, 3);
      end
      if (in_txn) begin
        chk_i("mem_stable_req", int'(bus.mem_req_o), 1);
        chk_i("mem_stable_addr", int'(bus.mem_addr_o), int'(cur.addr));
        if (cur.we) chk_l("mem_stable_wdata", bus.mem_wdata_o, cur.wdata);
        if (!no_ack) begin
          if (dly == 0) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = cur.we ? '0 : back_of(cur.addr);
            if (cur.we) backing[cur.addr] = cur.wdata;
            last_ack = cyc + 1;
            ack_prev = 1'b1;
            prev_wb  = cur.we;
            in_txn   = 1'b0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    line_t q_line;
    int    n;
    bus.re_L1D_L2 = 1'b0; bus.raddr_L1D_L2 = '0;
    bus.we_L1D_L2 = 1'b0; bus.waddr_L1D_L2 = '0; bus.wdata_L1D_L2 = '0;
    repeat (3) @(negedge clk);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_mem_req", int'(bus.mem_req_o), 0);
    chk_i("rst_read_hit", int'(bus.read_hit_L1D_L2), 0);
    chk_i("rst_write_hit", int'(bus.write_hit_L1D_L2), 0);
    chk_l("rst_rdata", bus.rdata_L1D_L2, '0);
    rst = 1'b1;

    do_op(1'b1, 1'b0, 32'h0000_1040, '0, '0);             // cold read: fill
    do_op(1'b1, 1'b0, 32'h0000_105F, '0, '0);             // same line: hit
    q_line = rand_line();
    do_op(1'b0, 1'b1, '0, 32'h0000_2000, q_line);         // write allocate
    do_op(1'b1, 1'b0, 32'h0000_2000, '0, '0);             // read back Q
    do_op(1'b1, 1'b0, 32'h0000_A000, '0, '0);             // evict Q, then fill
    do_op(1'b1, 1'b1, 32'h0000_1040, 32'h0000_2000, rand_line());

    // Reset while a fill is outstanding
    wait_idle();
    no_ack = 1'b1;
    bus.re_L1D_L2 = 1'b1; bus.raddr_L1D_L2 = 32'h0000_3020;
    predict(1'b0, 32'h0000_3020, '0, cyc + 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req_o && !bus.mem_we_o) && n < 50);
    if (n >= 50) fail("fill_req_timeout");
    rst = 1'b0;
    #1;
    chk_i("midfill_mem_req", int'(bus.mem_req_o), 0);
    chk_i("midfill_busy", int'(busy), 0);
    bus.re_L1D_L2 = 1'b0;
    resp_q.delete();
    mem_q.delete();
    for (int i = 0; i < NUM_LINES; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    gold = backing;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    no_ack = 1'b0;
    do_op(1'b1, 1'b0, 32'h0000_3020, '0, '0);             // must miss again

    for (int k = 0; k < 80; k++) begin
      int    kind = $urandom_range(0, 3);
      addr_t a1 = (addr_t'($urandom_range(0, 3)) << 11) | (addr_t'($urandom_range(0, 3)) << 5)
                | addr_t'($urandom_range(0, 31));
      addr_t a2 = (addr_t'($urandom_range(0, 3)) << 11) | (addr_t'($urandom_range(0, 3)) << 5)
                | addr_t'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case (kind)
        0, 1:    do_op(1'b1, 1'b0, a1, '0, '0);
        2:       do_op(1'b0, 1'b1, '0, a1, rand_line());
        default: do_op(1'b1, 1'b1, a1, a2, rand_line());
      endcase
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk_i("resp_queue_drained", resp_q.size(), 0);
    chk_i("mem_queue_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_l1d_responder.md
# l2_l1d_responder

L2-side responder for the L1D↔L2 line interface: accepts full-line read and write requests from the L1D and completes each with a single-cycle hit pulse. Backed by a direct-mapped, write-back, write-allocate line store that fills from and evicts to the next level through a req/ack memory port. Sits between the L1D and the L3/memory controller.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, line width in bits (32 B)
- OFFSET_BITS, 5, byte offset within a line
- INDEX_BITS, 6, line-store index (64 lines); tag = ADDR_W-INDEX_BITS-OFFSET_BITS = 21 bits
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- re_L1D_L2  in  1  read request; held with raddr until read_hit seen
- raddr_L1D_L2  in  ADDR_W  read address (offset bits ignored)
- rdata_L1D_L2  out  LINE_W  read line; valid only while read_hit_L1D_L2=1
- read_hit_L1D_L2  out  1  one-cycle read completion pulse
- we_L1D_L2  in  1  write request; held with waddr/wdata until write_hit seen
- waddr_L1D_L2  in  ADDR_W  write address (offset bits ignored)
- wdata_L1D_L2  in  LINE_W  full-line write data
- write_hit_L1D_L2  out  1  one-cycle write completion pulse
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  1=write-back, 0=fill
- mem_addr_o  out  ADDR_W  line-aligned address, offset bits 0
- mem_wdata_o  out  LINE_W  evicted line
- mem_rdata_i  in  LINE_W  fill data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOOKUP, WB, FILL, RESP, RECOVER.
- IDLE: if re=1 latch raddr, op=READ; else if we=1 latch waddr/wdata, op=WRITE; go LOOKUP. Read wins when both high; write stays pending and is served next.
- LOOKUP: hit = valid[idx] && tag[idx]==req tag.
  - READ hit → RESP. WRITE (hit or miss) → if miss and victim valid+dirty → WB, else write line, tag, valid=1, dirty=1 → RESP.
  - READ miss: victim valid+dirty → WB, else → FILL.
- WB: mem_req=1, mem_we=1, addr={victim tag, idx, 0}, wdata=victim line; on mem_ack: dirty[idx]=0; READ → FILL, WRITE → perform write → RESP.
- FILL: mem_req=1, mem_we=0, addr={req tag, idx, 0}; on mem_ack: line=mem_rdata, tag, valid=1, dirty=0 → RESP.
- RESP: drive the hit pulse for op (rdata = stored line for READ) for exactly one cycle → RECOVER.
- RECOVER: one idle cycle; requests ignored (initiator is still dropping re/we) → IDLE.
- Addresses differing only in offset bits map to the same line.

## Timing
- Reset (rst=0, async): state=IDLE; all outputs 0; valid and dirty arrays cleared; data/tag arrays not reset. Reset mid-WB/FILL abandons the transaction; mem_req drops immediately.
- Request sampled at posedge k in IDLE: read/write hit → hit pulse high in cycle k+2 (registered, asserted on posedge k+2, cleared posedge k+3).
- Miss: pulse 1 cycle after the final mem_ack is sampled.
- mem_req/mem_we/mem_addr/mem_wdata stable from assertion until the posedge sampling mem_ack; mem_req low the following cycle; back-to-back WB→FILL has exactly one mem_req-low cycle.
- Minimum request spacing: 4 cycles (IDLE, LOOKUP, RESP, RECOVER).
- Hit pulses never overlap; read_hit and write_hit never both high.

## Structure
- Package l2_pkg: width parameters, derived TAG_W, state enum, op enum (READ/WRITE), shared with the L1D side and the L1DL2 interface definition.
- Sub-module l2_line_store: data/tag/valid/dirty arrays, one synchronous write port, combinational read by index, async clear of valid/dirty. FSM and mem port stay in top.

## Test plan
- Cold read 0x0000_1040 → one mem fill at 0x0000_1040, mem_ack with pattern P → read_hit with rdata=P, no mem_we.
- Repeat read 0x0000_105F → hit pulse 2 cycles after sampling, rdata=P, no mem_req.
- Write 0x0000_2000 data Q, then read 0x0000_2000 → write_hit, then read_hit with Q; zero memory traffic.
- Dirty eviction: write 0x0000_2000=Q, read 0x0000_A000 (same idx 0) → mem write addr 0x0000_2000 wdata Q, then mem fill 0x0000_A000, then read_hit.
- re and we both high → read completes first, write_hit follows after RECOVER; each pulse exactly one cycle.
- Assert rst low mid-FILL → mem_req and busy_o drop immediately; after release, same read misses again (valid cleared).
